fetch_stage: RTL and testbench

- Instruction fetch stage that sits directly upstream of the decode/control unit.
- Owns the PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Captures the returned word and presents it with its PC to decode under a valid/ready handshake.
- Handles redirects (taken branch / JAL) from execute, discarding any in-flight stale response.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 32 +++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory and decode handshakes seen by the fetch stage.
interface fetch_stage_if #(
    parameter int XLEN = 32
) ();

    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_rsp_valid_i;
    logic [XLEN-1:0] imem_rsp_data_i;

    logic            id_valid_o;
    logic            id_ready_i;
    logic [XLEN-1:0] id_instr_o;
    logic [XLEN-1:0] id_pc_o;
    logic [XLEN-1:0] id_pc_plus4_o;

    modport stage (
        output imem_req_valid_o, imem_addr_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        output id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o,
        input  id_ready_i
    );

    modport env (
        input  imem_req_valid_o, imem_addr_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        input  id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o,
        output id_ready_i
    );

endinterface

// File: rtl/fetch_stage.sv
// Single-outstanding-request fetch stage: owns the PC, fetches one word at a
// time and holds it for decode; redirects squash any in-flight response.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN      = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(fetch_pkg::NOP_INSTR)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    fetch_stage_if.stage    bus
);

    fetch_state_t    r_state, w_state_next;
    logic [XLEN-1:0] r_pc, w_pc_next;
    logic            r_id_valid, w_id_valid_next;
    logic [XLEN-1:0] r_instr, w_instr_next;
    logic [XLEN-1:0] r_id_pc, w_id_pc_next;

    logic            w_req_fire;
    logic            w_rsp;
    logic [XLEN-1:0] w_target;

    assign w_req_fire = (r_state == S_REQ) && bus.imem_req_ready_i && !rst_i;
    assign w_rsp      = bus.imem_rsp_valid_i;
    assign w_target   = redirect_pc_i & ~XLEN'(3);

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_id_valid_next = r_id_valid;
        w_instr_next    = r_instr;
        w_id_pc_next    = r_id_pc;

        if (redirect_i) begin
            // Redirect wins; only the owed-response bookkeeping depends on state.
            w_pc_next       = w_target;
            w_id_valid_next = 1'b0;
            w_instr_next    = NOP_INSTR;
            unique case (r_state)
                S_REQ:   w_state_next = w_req_fire ? S_DROP : S_REQ;
                S_WAIT:  w_state_next = w_rsp ? S_REQ : S_DROP;
                S_HOLD:  w_state_next = S_REQ;
                S_DROP:  w_state_next = w_rsp ? S_REQ : S_DROP;
                default: w_state_next = S_REQ;
            endcase
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (w_req_fire) w_state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (w_rsp) begin
                        w_instr_next    = bus.imem_rsp_data_i;
                        w_id_pc_next    = r_pc;
                        w_id_valid_next = 1'b1;
                        w_state_next    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.id_ready_i) begin
                        w_pc_next       = r_pc + XLEN'(4);
                        w_id_valid_next = 1'b0;
                        w_instr_next    = NOP_INSTR;
                        w_state_next    = S_REQ;
                    end
                end
                S_DROP: begin
                    if (w_rsp) w_state_next = S_REQ;
                end
                default: w_state_next = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_id_pc    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_id_valid <= w_id_valid_next;
            r_instr    <= w_instr_next;
            r_id_pc    <= w_id_pc_next;
        end
    end

    // A response with no request outstanding is a memory-side protocol error.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(w_rsp && (r_state == S_REQ || r_state == S_HOLD)))
                else $error("fetch_stage: imem response with no request outstanding");
        end
    end

    assign bus.imem_req_valid_o = (r_state == S_REQ) && !rst_i;
    assign bus.imem_addr_o      = r_pc;
    assign bus.id_valid_o       = r_id_valid;
    assign bus.id_instr_o       = r_instr;
    assign bus.id_pc_o          = r_id_pc;
    assign bus.id_pc_plus4_o    = r_id_pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays memory and decode cycle by cycle.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    int n_cmp = 0;
    int n_err = 0;

    fetch_stage_if #(.XLEN(32)) bus ();

    fetch_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .bus          (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [31:0] instr,
                          input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, bus.id_valid_o}, {31'd0, v});
        chk({tag, ".instr"}, bus.id_instr_o, instr);
        chk({tag, ".pc"},    bus.id_pc_o, pc);
        chk({tag, ".pc4"},   bus.id_pc_plus4_o, pc + 32'd4);
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [31:0] addr);
        chk({tag, ".rqv"}, {31'd0, bus.imem_req_valid_o}, {31'd0, v});
        if (v) chk({tag, ".addr"}, bus.imem_addr_o, addr);
    endtask

    initial begin
        rst_i                = 1'b1;
        redirect_i           = 1'b0;
        redirect_pc_i        = '0;
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;
        bus.id_ready_i       = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst.rqv", {31'd0, bus.imem_req_valid_o}, 32'd0);
        chk("rst.valid", {31'd0, bus.id_valid_o}, 32'd0);
        chk("rst.instr", bus.id_instr_o, 32'h0000_0013);
        chk("rst.pc", bus.id_pc_o, 32'h0);
        rst_i = 1'b0;
        #1;
        chk_req("rel", 1'b1, 32'h0);

        // Basic fetch with 1-cycle memory latency
        bus.imem_req_ready_i = 1'b1;
        tick();
        bus.imem_req_ready_i = 1'b0;
        chk_req("wait", 1'b0, 32'h0);
        chk("wait.valid", {31'd0, bus.id_valid_o}, 32'd0);
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 32'h0050_0093;
        tick();
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = 32'hFFFF_FFFF;
        chk_id("hold", 1'b1, 32'h0050_0093, 32'h0);
        chk_req("hold", 1'b0, 32'h0);

        // Decode stall for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_id("stall", 1'b1, 32'h0050_0093, 32'h0);
            chk_req("stall", 1'b0, 32'h0);
            chk("stall.pc", bus.imem_addr_o, 32'h0);
        end
        bus.id_ready_i = 1'b1;
        tick();
        bus.id_ready_i = 1'b0;
        chk_req("next", 1'b1, 32'h4);
        chk("next.valid", {31'd0, bus.id_valid_o}, 32'd0);
        chk("next.instr", bus.id_instr_o, 32'h0000_0013);

        // Redirect in S_WAIT, stale response 3 cycles later
        bus.imem_req_ready_i = 1'b1;
        tick();
        bus.imem_req_ready_i = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        tick();
        redirect_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk_req("drop", 1'b0, 32'h0);
            chk("drop.valid", {31'd0, bus.id_valid_o}, 32'd0);
            tick();
        end
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rsp_valid_i = 1'b0;
        chk("drop.valid2", {31'd0, bus.id_valid_o}, 32'd0);
        chk("drop.instr", bus.id_instr_o, 32'h0000_0013);
        chk_req("redir", 1'b1, 32'h0000_0100);

        // Redirect coincident with response in S_WAIT
        bus.imem_req_ready_i = 1'b1;
        tick();
        bus.imem_req_ready_i = 1'b0;
        redirect_i           = 1'b1;
        redirect_pc_i        = 32'h0000_0200;
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 32'h0BAD_0BAD;
        tick();
        redirect_i           = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        chk_req("coin", 1'b1, 32'h0000_0200);
        chk("coin.valid", {31'd0, bus.id_valid_o}, 32'd0);
        chk("coin.instr", bus.id_instr_o, 32'h0000_0013);

        // Redirect in S_HOLD while decode accepts
        bus.imem_req_ready_i = 1'b1;
        tick();
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 32'h00A0_0113;
        tick();
        bus.imem_rsp_valid_i = 1'b0;
        chk_id("hold2", 1'b1, 32'h00A0_0113, 32'h0000_0200);
        bus.id_ready_i = 1'b1;
        redirect_i     = 1'b1;
        redirect_pc_i  = 32'h0000_0300;
        tick();
        bus.id_ready_i = 1'b0;
        redirect_i     = 1'b0;
        chk_req("hredir", 1'b1, 32'h0000_0300);
        chk("hredir.valid", {31'd0, bus.id_valid_o}, 32'd0);
        chk("hredir.instr", bus.id_instr_o, 32'h0000_0013);

        // PC wrap and request held while memory not ready
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        tick();
        redirect_i = 1'b0;
        chk_req("top", 1'b1, 32'hFFFF_FFFC);
        bus.imem_req_ready_i = 1'b1;
        tick();
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 32'h0000_0073;
        tick();
        bus.imem_rsp_valid_i = 1'b0;
        chk_id("top", 1'b1, 32'h0000_0073, 32'hFFFF_FFFC);
        chk("top.pc4", bus.id_pc_plus4_o, 32'h0000_0000);
        bus.id_ready_i = 1'b1;
        tick();
        bus.id_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_req("wrap", 1'b1, 32'h0000_0000);
            tick();
        end
        chk_req("wrap", 1'b1, 32'h0000_0000);
        bus.imem_req_ready_i = 1'b1;
        tick();
        bus.imem_req_ready_i = 1'b0;
        chk_req("acc", 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
